// File: rtl/edge_event_arbiter_pkg.sv
// edge_event_arbiter_pkg: default channel/counter sizes and the channel-index width helper
package edge_event_arbiter_pkg;
  localparam int N_DEF = 4;
  localparam int CNTW_DEF = 8;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/edge_pend_cell.sv
// edge_pend_cell: one channel; Clk/Rst/In/load/OvfClr in, pending and sticky Overflow out
module edge_pend_cell (
  input  logic Clk,
  input  logic Rst,
  input  logic In,
  input  logic load,
  input  logic OvfClr,
  output logic pending,
  output logic Overflow
);
  logic prev, rise;
  assign rise = In & ~prev;
  always_ff @(posedge Clk)
    if (Rst) begin
      prev <= In;
      pending <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      prev <= In;
      pending <= rise | (pending & ~load);
      Overflow <= (rise & pending & ~load) | (Overflow & ~OvfClr);
    end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: N rising-edge channels queued and issued round-robin over EvtValid/EvtReady with Overflow and EvtCount
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IDW = idx_w(N),
  parameter int CNTW = CNTW_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N-1:0]    In,
  input  logic            EvtReady,
  input  logic            OvfClr,
  output logic            EvtValid,
  output logic [IDW-1:0]  EvtId,
  output logic [N-1:0]    Overflow,
  output logic [CNTW-1:0] EvtCount
);
  logic [N-1:0] pend;
  logic [IDW-1:0] rr, win;
  logic any, load;
  function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] b, input int k);
    return IDW'(int'(b) + k >= N ? int'(b) + k - N : int'(b) + k);
  endfunction
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--) win = pend[rot(rr, k)] ? rot(rr, k) : win;
  end
  assign any = |pend;
  assign load = any && (!EvtValid || EvtReady);
  for (genvar g = 0; g < N; g++) begin : g_cell
    edge_pend_cell u_cell (
      .Clk(Clk),
      .Rst(Rst),
      .In(In[g]),
      .load(load && win == IDW'(g)),
      .OvfClr(OvfClr),
      .pending(pend[g]),
      .Overflow(Overflow[g])
    );
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      EvtValid <= 1'b0;
      EvtId <= '0;
      rr <= '0;
      EvtCount <= '0;
    end else begin
      if (!EvtValid || EvtReady) EvtValid <= any;
      if (load) begin
        EvtId <= win;
        rr <= win == IDW'(N - 1) ? '0 : win + 1'b1;
      end
      if (EvtValid && EvtReady) EvtCount <= EvtCount + 1'b1;
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: vector table, fairness/wrap sequences and random run against a reference model
module tb_edge_event_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int CNTW = 8;
  logic Clk = 1'b0;
  logic Rst, EvtReady, OvfClr, EvtValid;
  logic [N-1:0] In, Overflow;
  logic [IDW-1:0] EvtId;
  logic [CNTW-1:0] EvtCount;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic rst;
    logic [3:0] lvl;
    logic rdy;
    logic clr;
    logic v;
    logic [1:0] id;
    logic [3:0] ovf;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[$];
  logic [N-1:0] m_prev, m_pend, m_ovf;
  logic m_valid;
  int m_id, m_rr;
  logic [CNTW-1:0] m_cnt;
  edge_event_arbiter #(.N(N), .IDW(IDW), .CNTW(CNTW)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .In(In),
    .EvtReady(EvtReady),
    .OvfClr(OvfClr),
    .EvtValid(EvtValid),
    .EvtId(EvtId),
    .Overflow(Overflow),
    .EvtCount(EvtCount)
  );
  always #5 Clk = ~Clk;
  function automatic void add(logic r, logic [3:0] l, logic y, logic c, logic v, logic [1:0] id, logic [3:0] o, logic [7:0] n);
    tbl.push_back('{r, l, y, c, v, id, o, n});
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic model_edge();
    logic [N-1:0] rise;
    int g;
    if (Rst) begin
      m_valid = 1'b0;
      m_id = 0;
      m_rr = 0;
      m_cnt = '0;
      m_pend = '0;
      m_ovf = '0;
      m_prev = In;
      return;
    end
    rise = In & ~m_prev;
    m_prev = In;
    g = -1;
    if (m_valid && EvtReady) m_cnt++;
    if (!m_valid || EvtReady) begin
      for (int k = 0; k < N; k++) if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      m_valid = g >= 0;
      if (g >= 0) begin
        m_id = g;
        m_rr = (g + 1) % N;
      end
    end
    if (OvfClr) m_ovf = '0;
    for (int i = 0; i < N; i++) if (rise[i] && m_pend[i] && i != g) m_ovf[i] = 1'b1;
    if (g >= 0) m_pend[g] = 1'b0;
    m_pend |= rise;
  endtask
  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    Rst = 1'b1; In = '0; EvtReady = 1'b0; OvfClr = 1'b0;
    add(1, 4'b0101, 0, 0, 0, 0, 4'b0000, 0);
    add(1, 4'b0101, 0, 0, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 10; i++) add(0, 4'b0101, 0, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b0100, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b0100, 1, 0, 1, 2, 4'b0000, 0);
    add(0, 4'b0100, 1, 0, 0, 2, 4'b0000, 1);
    add(0, 4'b0100, 1, 0, 0, 2, 4'b0000, 1);
    add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 0, 0, 4'b0000, 0);
    for (int j = 0; j < 4; j++) add(0, 4'b1111, 1, 0, 1, 2'(j), 4'b0000, 8'(j));
    add(0, 4'b1111, 1, 0, 0, 3, 4'b0000, 4);
    add(0, 4'b1111, 1, 0, 0, 3, 4'b0000, 4);
    add(0, 4'b0000, 0, 0, 0, 3, 4'b0000, 4);
    add(0, 4'b0010, 0, 0, 0, 3, 4'b0000, 4);
    add(0, 4'b0000, 0, 0, 1, 1, 4'b0000, 4);
    add(0, 4'b0010, 0, 0, 1, 1, 4'b0000, 4);
    add(0, 4'b0000, 0, 0, 1, 1, 4'b0000, 4);
    add(0, 4'b0010, 0, 0, 1, 1, 4'b0010, 4);
    add(0, 4'b0000, 0, 0, 1, 1, 4'b0010, 4);
    add(0, 4'b0010, 0, 1, 1, 1, 4'b0010, 4);
    add(0, 4'b0000, 0, 1, 1, 1, 4'b0000, 4);
    add(0, 4'b0000, 0, 0, 1, 1, 4'b0000, 4);
    add(0, 4'b1101, 0, 0, 1, 1, 4'b0000, 4);
    add(0, 4'b0000, 0, 0, 1, 1, 4'b0000, 4);
    add(0, 4'b1101, 0, 0, 1, 1, 4'b1101, 4);
    add(1, 4'b1101, 0, 0, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b1101, 1, 0, 0, 0, 4'b0000, 0);
    for (int t = 0; t < tbl.size(); t++) begin
      Rst = tbl[t].rst; In = tbl[t].lvl; EvtReady = tbl[t].rdy; OvfClr = tbl[t].clr;
      step();
      chk($sformatf("row%0d valid", t), 32'(EvtValid), 32'(tbl[t].v));
      chk($sformatf("row%0d id", t), 32'(EvtId), 32'(tbl[t].id));
      chk($sformatf("row%0d overflow", t), 32'(Overflow), 32'(tbl[t].ovf));
      chk($sformatf("row%0d count", t), 32'(EvtCount), 32'(tbl[t].cnt));
    end
    Rst = 1'b1; In = '0; EvtReady = 1'b1; OvfClr = 1'b0;
    step();
    Rst = 1'b0; In = '1;
    step();
    for (int j = 0; j < 8; j++) begin
      In = ~In;
      step();
      chk($sformatf("fair%0d valid", j), 32'(EvtValid), 32'd1);
      chk($sformatf("fair%0d id", j), 32'(EvtId), 32'(j % 4));
    end
    for (int b = 0; b < 400 && EvtCount != 8'hFF; b++) begin
      In = ~In;
      step();
    end
    chk("count at 255", 32'(EvtCount), 32'd255);
    chk("valid at 255", 32'(EvtValid), 32'd1);
    In = ~In;
    step();
    chk("count wrap", 32'(EvtCount), 32'd0);
    Rst = 1'b1;
    step();
    for (int c = 0; c < 500; c++) begin
      Rst = $urandom_range(49) == 0;
      In = 4'($urandom);
      EvtReady = $urandom_range(9) < 7;
      OvfClr = $urandom_range(9) == 0;
      step();
      chk($sformatf("rand%0d valid", c), 32'(EvtValid), 32'(m_valid));
      chk($sformatf("rand%0d id", c), 32'(EvtId), 32'(m_id));
      chk($sformatf("rand%0d overflow", c), 32'(Overflow), 32'(m_ovf));
      chk($sformatf("rand%0d count", c), 32'(EvtCount), 32'(m_cnt));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
